// File: rtl/alu_issue_wb.sv
// Issue/writeback wrapper for the combinational MIPS-subset alu: instruction FIFO,
// single exec stage, registered result stage and the two-entry register array.
module alu_issue_wb #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] INIT_A     = 32'h0000_0000,
  parameter logic [31:0] INIT_B     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic [31:0] alu_instr,
  output logic [31:0] alu_rega,
  output logic [31:0] alu_regb,
  input  logic [31:0] alu_result,
  input  logic [2:0]  alu_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [2:0]  out_flags,
  output logic        illegal,
  output logic [31:0] rega_q,
  output logic [31:0] regb_q
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0021;

  function automatic logic is_supported(input logic [5:0] op, input logic [5:0] funct);
    logic ok;
    ok = 1'b0;
    case (op)
      6'b000000: begin
        case (funct)
          6'b100000, 6'b100001, 6'b100010, 6'b100011,
          6'b100100, 6'b100101, 6'b100110, 6'b100111,
          6'b101010: ok = 1'b1;
          default:   ok = 1'b0;
        endcase
      end
      6'b001000, 6'b001001, 6'b001100, 6'b001101,
      6'b001110, 6'b000100, 6'b000101: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Returns {write regB, write regA}; targets other than r0/r1 are dropped.
  function automatic logic [1:0] wb_sel(input logic [5:0] op, input logic [5:0] funct,
                                        input logic [4:0] rt, input logic [4:0] rd);
    logic [4:0] tgt;
    logic       en;
    tgt = rt;
    en  = 1'b0;
    case (op)
      6'b000000: begin
        tgt = rd;
        en  = (funct != 6'b101010);
      end
      6'b000100, 6'b000101: begin
        tgt = rt;
        en  = 1'b0;
      end
      default: begin
        tgt = rt;
        en  = 1'b1;
      end
    endcase
    return {en && (tgt == 5'd1), en && (tgt == 5'd0)};
  endfunction

  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]   exec_q, exec_d;
  logic          exec_v_q, exec_v_d;
  logic          out_valid_q, out_valid_d;
  logic [31:0]   out_result_q, out_result_d;
  logic [2:0]    out_flags_q, out_flags_d;
  logic          illegal_q, illegal_d;
  logic [31:0]   rega_d, regb_d;
  logic          empty_s, full_s, push_s, pop_s, adv_s, head_ok_s;
  logic [31:0]   head_s;
  logic [1:0]    wb_s;

  // Next-state logic for FIFO pointers, exec stage, output stage and registers.
  always_comb begin
    empty_s   = (wr_ptr_q == rd_ptr_q);
    full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    push_s    = in_valid && !full_s;
    adv_s     = exec_v_q && (!out_valid_q || out_ready);
    pop_s     = !empty_s && (!exec_v_q || adv_s);
    head_s    = mem_q[rd_ptr_q[AW-1:0]];
    head_ok_s = is_supported(head_s[31:26], head_s[5:0]);
    wb_s      = wb_sel(exec_q[31:26], exec_q[5:0], exec_q[20:16], exec_q[15:11]);

    wr_ptr_d     = push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d     = pop_s ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    illegal_d    = pop_s && !head_ok_s;
    exec_d       = exec_q;
    exec_v_d     = exec_v_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_flags_d  = out_flags_q;
    rega_d       = rega_q;
    regb_d       = regb_q;

    if (pop_s && head_ok_s) begin
      exec_d   = head_s;
      exec_v_d = 1'b1;
    end else if (adv_s) begin
      exec_v_d = 1'b0;
    end else begin
      exec_v_d = exec_v_q;
    end

    // Writeback lands on the same edge the next instruction enters exec.
    if (adv_s) begin
      out_result_d = alu_result;
      out_flags_d  = alu_flags;
      out_valid_d  = 1'b1;
      rega_d       = wb_s[0] ? alu_result : rega_q;
      regb_d       = wb_s[1] ? alu_result : regb_q;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= in_instr;
    end
  end

  // Pipeline state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      exec_q       <= 32'h0000_0000;
      exec_v_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= 32'h0000_0000;
      out_flags_q  <= 3'b000;
      illegal_q    <= 1'b0;
      rega_q       <= INIT_A;
      regb_q       <= INIT_B;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      exec_q       <= exec_d;
      exec_v_q     <= exec_v_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_flags_q  <= out_flags_d;
      illegal_q    <= illegal_d;
      rega_q       <= rega_d;
      regb_q       <= regb_d;
    end
  end

  assign in_ready   = !full_s;
  assign alu_instr  = exec_v_q ? exec_q : NOP_INSTR;
  assign alu_rega   = rega_q;
  assign alu_regb   = regb_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_alu_issue_wb.sv
// Bench for alu_issue_wb: behavioural alu in the environment, architectural
// reference model (sequential ISA semantics) feeding an output scoreboard.
module tb_alu_issue_wb;

  localparam logic [31:0] INIT_A = 32'h7FFF_FFFF;
  localparam logic [31:0] INIT_B = 32'h0000_0000;

  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready, illegal;
  logic [31:0] in_instr, alu_instr, alu_rega, alu_regb, alu_result, out_result, rega_q, regb_q;
  logic [2:0]  alu_flags, out_flags;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  fl;
    logic [31:0] ra;
    logic [31:0] rb;
  } exp_t;

  exp_t        q[$];
  logic [31:0] ma, mb;
  int          n_tests, n_fail, exp_illegal, seen_illegal, n_out;
  bit          pushes_done;

  alu_issue_wb #(.FIFO_DEPTH(4), .INIT_A(INIT_A), .INIT_B(INIT_B)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .alu_instr(alu_instr), .alu_rega(alu_rega), .alu_regb(alu_regb),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_flags(out_flags), .illegal(illegal), .rega_q(rega_q), .regb_q(regb_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ISA semantics: returns {flags, result}; r0=regA, r1=regB, other indices read 0.
  function automatic logic [34:0] isa_eval(input logic [31:0] w, input logic [31:0] ra,
                                           input logic [31:0] rb);
    logic [31:0] a, b, r, imm_s, imm_z;
    logic        ovf;
    a     = (w[25:21] == 5'd0) ? ra : (w[25:21] == 5'd1) ? rb : 32'd0;
    b     = (w[20:16] == 5'd0) ? ra : (w[20:16] == 5'd1) ? rb : 32'd0;
    imm_s = {{16{w[15]}}, w[15:0]};
    imm_z = {16'd0, w[15:0]};
    r     = 32'd0;
    ovf   = 1'b0;
    case (w[31:26])
      6'h00: case (w[5:0])
        6'h20: begin r = a + b; ovf = (a[31] == b[31]) && (r[31] != a[31]); end
        6'h21: r = a + b;
        6'h22: begin r = a - b; ovf = (a[31] != b[31]) && (r[31] != a[31]); end
        6'h23: r = a - b;
        6'h24: r = a & b;
        6'h25: r = a | b;
        6'h26: r = a ^ b;
        6'h27: r = ~(a | b);
        6'h2a: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        default: r = 32'd0;
      endcase
      6'h08: begin r = a + imm_s; ovf = (a[31] == imm_s[31]) && (r[31] != a[31]); end
      6'h09: r = a + imm_s;
      6'h0c: r = a & imm_z;
      6'h0d: r = a | imm_z;
      6'h0e: r = a ^ imm_z;
      6'h04, 6'h05: begin r = a - b; ovf = (a[31] != b[31]) && (r[31] != a[31]); end
      default: r = 32'd0;
    endcase
    return {ovf, r[31] ^ ovf, r == 32'd0, r};
  endfunction

  assign {alu_flags, alu_result} = isa_eval(alu_instr, alu_rega, alu_regb);

  function automatic bit tb_legal(input logic [31:0] w);
    logic [5:0] op, fn;
    op = w[31:26];
    fn = w[5:0];
    if (op == 6'h00) return fn inside {[6'h20:6'h27], 6'h2a};
    return op inside {6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0e, 6'h04, 6'h05};
  endfunction

  function automatic int wb_target(input logic [31:0] w);
    if (w[31:26] == 6'h00) return (w[5:0] == 6'h2a) ? -1 : int'(w[15:11]);
    if (w[31:26] inside {6'h04, 6'h05}) return -1;
    return int'(w[20:16]);
  endfunction

  task automatic model_accept(input logic [31:0] w);
    logic [34:0] v;
    int          t;
    exp_t        e;
    if (!tb_legal(w)) begin
      exp_illegal++;
    end else begin
      v = isa_eval(w, ma, mb);
      t = wb_target(w);
      if (t == 0) ma = v[31:0];
      else if (t == 1) mb = v[31:0];
      e.res = v[31:0]; e.fl = v[34:32]; e.ra = ma; e.rb = mb;
      q.push_back(e);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    int k;
    k = 0;
    in_valid = 1'b1;
    in_instr = w;
    while (!in_ready && k < 200) begin @(negedge clk); k++; end
    if (k >= 200) begin
      n_tests++; n_fail++;
      $error("FAIL push_timeout: observed in_ready=0 expected 1 within 200 cycles");
      in_valid = 1'b0;
    end else begin
      model_accept(w);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic expect_out(input string tag, input logic [31:0] r, input logic [2:0] f);
    int k;
    k = 0;
    while (!(out_valid && out_ready) && k < 50) begin @(negedge clk); #1; k++; end
    if (k >= 50) begin
      n_tests++; n_fail++;
      $error("FAIL %s_timeout: observed no out_valid expected one within 50 cycles", tag);
    end else begin
      chk({tag, "_result"}, out_result, r);
      chk({tag, "_flags"}, {29'd0, out_flags}, {29'd0, f});
    end
    @(negedge clk); #1;
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while (q.size() != 0 && k < 1000) begin @(negedge clk); k++; end
    if (q.size() != 0) begin
      n_tests++; n_fail++;
      $error("FAIL %s_drain: observed %0d pending expected 0", tag, q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [31:0] gen_word(input bit allow_bad);
    logic [5:0] fn_tab [9] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a};
    logic [5:0] op_tab [7] = '{6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0e, 6'h04, 6'h05};
    logic [4:0] rs, rt, rd;
    int         kind;
    kind = allow_bad ? int'($urandom_range(0, 9)) : int'($urandom_range(2, 9));
    rs = 5'($urandom_range(0, 1));
    rt = 5'($urandom_range(0, 2));
    rd = 5'($urandom_range(0, 2));
    if (kind == 0) return {6'h23, 26'($urandom)};
    if (kind == 1) return {6'h00, 20'($urandom), 6'h00};
    if (kind < 6) return {6'h00, rs, rt, rd, 5'd0, fn_tab[$urandom_range(0, 8)]};
    return {op_tab[$urandom_range(0, 6)], rs, rt, 16'($urandom)};
  endfunction

  // Output scoreboard and illegal-pulse counter, sampled between clock edges.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst_n) begin
      if (illegal) seen_illegal++;
      if (out_valid && out_ready) begin
        n_out++;
        if (q.size() == 0) begin
          chk("spurious_out", {31'd0, out_valid}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("sb_result", out_result, e.res);
          chk("sb_flags", {29'd0, out_flags}, {29'd0, e.fl});
          chk("sb_rega", rega_q, e.ra);
          chk("sb_regb", regb_q, e.rb);
        end
      end
    end
  end

  initial begin
    int out_base;
    n_tests = 0; n_fail = 0; exp_illegal = 0; seen_illegal = 0; n_out = 0;
    pushes_done = 1'b0;
    ma = INIT_A; mb = INIT_B;
    rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'd0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    chk("rst_out_flags", {29'd0, out_flags}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_rega", rega_q, INIT_A);
    chk("rst_regb", regb_q, INIT_B);
    chk("rst_alu_instr", alu_instr, 32'h0000_0021);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    push(32'h0000_0020);
    expect_out("ovf_add", 32'hFFFF_FFFE, 3'b100);
    chk("ovf_rega", rega_q, 32'hFFFF_FFFE);
    push(32'h0001_0024);
    expect_out("clr_a", 32'd0, 3'b001);

    push(32'h2000_0005);
    push(32'h2021_0007);
    expect_out("addi_a", 32'd5, 3'b000);
    expect_out("addi_b", 32'd7, 3'b000);
    chk("addi_rega", rega_q, 32'd5);
    chk("addi_regb", regb_q, 32'd7);

    push(32'h0001_0020);
    #1;
    chk("lat_edge0", {31'd0, out_valid}, 32'd0);
    @(negedge clk); #1;
    chk("lat_edge1", {31'd0, out_valid}, 32'd0);
    @(negedge clk); #1;
    chk("lat_edge2", {31'd0, out_valid}, 32'd1);
    chk("lat_result", out_result, 32'd12);
    @(negedge clk); #1;
    chk("add_rega", rega_q, 32'd12);

    push(32'h0000_0026);
    push(32'h2000_0003);
    push(32'h0021_0826);
    push(32'h2021_0003);
    drain("beq_setup");
    chk("beq_pre_rega", rega_q, 32'd3);
    chk("beq_pre_regb", regb_q, 32'd3);
    push(32'h1001_0000);
    expect_out("beq", 32'd0, 3'b001);
    chk("beq_rega", rega_q, 32'd3);
    chk("beq_regb", regb_q, 32'd3);

    push(32'h8C00_0000);
    repeat (3) @(negedge clk);
    #1;
    chk("lw_illegal_cnt", 32'(seen_illegal), 32'(exp_illegal));
    chk("lw_no_out", {31'd0, out_valid}, 32'd0);
    @(negedge clk);

    out_ready = 1'b0;
    out_base = n_out;
    for (int i = 0; i < 6; i++) push(gen_word(1'b0));
    #1;
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    out_ready = 1'b1;
    drain("stall");
    chk("stall_out_count", 32'(n_out - out_base), 32'd6);

    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(gen_word(1'b0));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_rega", rega_q, INIT_A);
    chk("mid_rst_regb", regb_q, INIT_B);
    q.delete();
    ma = INIT_A; mb = INIT_B;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);

    fork
      begin
        for (int i = 0; i < 200; i++) begin
          if ($urandom_range(0, 3) == 0) @(negedge clk);
          push(gen_word(1'b1));
        end
        pushes_done = 1'b1;
      end
      begin
        while (!pushes_done) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain("random");
    chk("rand_illegal_cnt", 32'(seen_illegal), 32'(exp_illegal));
    chk("rand_rega", rega_q, ma);
    chk("rand_regb", regb_q, mb);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
